os_array_ctrl: RTL and testbench
================================

Name: os_array_ctrl

Overview:
- Sequencer for the mac_tile array in Output Stationary mode (WeightOrOutput=1).
- Issues inst_w to the west edge and pops activations (IFIFO) and weights (north feeder FIFO) in lockstep.
- Counts the acc_kij accumulation beats per pass and ping-pongs two output tiles across input_ch channel passes.
- Drains finished psums to the OFIFO, then reports done; sits between the core top-level FSM and the array/FIFO instances.

Parameters:
acc_kij, 9, accumulation beats per channel pass (kernel positions)
input_ch, 3, channel passes per output tile
row, 8, array rows = OS_out words drained per tile
skew, 14, pipeline skew cycles flushed after the last execute beat (row+col-2 for 8x8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
start  input  1  one-cycle request to run one OS job; sampled in IDLE only
ififo_empty  input  1  activation FIFO empty
wfifo_empty  input  1  weight FIFO empty
ofifo_full  input  1  output FIFO full
inst_w  output  2  to array west edge; [1]=execute, [0]=kernel load; always 2'b00 or 2'b10 here
ififo_rd  output  1  pop activation FIFO
wfifo_rd  output  1  pop weight FIFO
ififo_loop  output  1  one-cycle pulse: IFIFO rewinds to the pass start
ofifo_wr  output  1  push one drained word to OFIFO
tile_sel  output  1  tile receiving the current pass (0/1)
kij_cnt  output  4  current beat index 0..acc_kij-1
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at job end

Behaviour:
- Reset (reset=0, async): state=IDLE, all counters=0, tile_sel=0; every output is 0.
- States: IDLE, EXEC, SWAP, FLUSH, DRAIN, DONE.
- IDLE: when start=1, go to EXEC next cycle; otherwise stay. start in any other state is ignored.
- EXEC, beat rule: a beat fires when ififo_empty=0 and wfifo_empty=0.
  - On a beat, assert inst_w=2'b10, ififo_rd=1 and wfifo_rd=1 in the same cycle, and increment kij_cnt.
  - Without a beat, inst_w=2'b00, both rd=0, and counters hold (stall bubble).
- EXEC exit: on the beat with kij_cnt=acc_kij-1, set kij_cnt to 0 and go to SWAP.
- SWAP (exactly 1 cycle):
  - inst_w=00, no pops; increment the ic count of the current tile.
  - ififo_loop=1 only when tile_sel=1, so both tiles reuse the same activation window per channel.
  - Toggle tile_sel.
  - Then go to FLUSH if both tile ic counts equal input_ch; otherwise return to EXEC.
- FLUSH: inst_w=00 for exactly skew cycles (internal counter), then go to DRAIN.
- DRAIN: emit 2*row words, tile0 first.
  - ofifo_wr=1 on each cycle with ofifo_full=0.
  - When ofifo_full=1, ofifo_wr=0 and the drain counter holds. ofifo_wr is never asserted while full.
  - After the final write, go to DONE.
- DONE: done=1 for one cycle; clear the ic counts and tile_sel; go to IDLE.
- Latency, no stalls: start to done = 1 + input_ch*2*(acc_kij+1) + skew + 2*row + 1 cycles = 92 with defaults.
- Widths:
  - kij_cnt saturates its range at acc_kij-1 and never wraps past it.
  - Internal ic counts are 4 bits; input_ch<=15 is required.
- Simultaneous events:
  - An empty FIFO during the last beat stalls that beat; SWAP is not entered until the beat fires.
  - An ofifo_full rise and fall in the same drain keeps the word order.
- reset=0 mid-job: immediate return to IDLE with outputs 0. No partial done pulse. The FIFO contents are the owner's problem.

Optional Feature:
- Macro OS_CTRL_PERF_EN.
- Defined: add output stall_cnt [15:0], counting EXEC cycles without a beat plus DRAIN cycles blocked by ofifo_full.
  - Saturates at 16'hFFFF.
  - Cleared on reset and on the IDLE->EXEC transition.
  - Holds its value after done.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset during EXEC (kij_cnt=5, tile_sel=1) -> busy, inst_w and all pulses 0 within the same cycle; IDLE.
- FIFOs never empty, OFIFO never full, start pulse -> exactly 54 execute beats; ififo_loop pulses 3 times; 16 ofifo_wr; done 92 cycles after start.
- ififo_empty held high 4 cycles at kij_cnt=3 -> 4 bubbles with inst_w=00 and kij_cnt held at 3; done delayed by exactly 4 cycles.
- ofifo_full high for 3 cycles mid-DRAIN -> no ofifo_wr during those cycles; total writes still 16; done delayed 3 cycles.
- start re-asserted while busy -> ignored; a second start after done runs a complete new job with identical timing.
- OS_CTRL_PERF_EN defined, with the stalls of the two stall scenarios above combined -> stall_cnt=7 at done; recompiled without the macro, the same port-less build passes the no-stall scenario.

Source files
------------

// File: rtl/os_array_ctrl.sv
// -----------------------------------------------------------------------------
// os_array_ctrl
//   Sequencer for the mac_tile array in Output Stationary mode. It issues
//   execute instructions to the west edge of the array and pops the activation
//   FIFO (IFIFO) and the north weight FIFO together, one pop of each per beat.
//   Each channel pass is acc_kij beats long. Passes alternate between two
//   output tiles (ping-pong) until both tiles have seen input_ch passes. The
//   controller then flushes the array pipeline skew and drains 2*row finished
//   words into the OFIFO, tile 0 first, and pulses done.
//
//   Optional build macro: OS_CTRL_PERF_EN adds the stall_cnt output.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle job request, honoured in IDLE only
//   ififo_empty  activation FIFO empty
//   wfifo_empty  weight FIFO empty
//   ofifo_full   output FIFO full
//   inst_w       west-edge instruction ([1]=execute, [0]=kernel load, always 0)
//   ififo_rd     pop the activation FIFO
//   wfifo_rd     pop the weight FIFO
//   ififo_loop   one-cycle pulse: IFIFO rewinds to the start of the pass
//   ofifo_wr     push one drained word into the OFIFO
//   tile_sel     output tile receiving the current pass
//   kij_cnt      current beat index inside the pass
//   busy         high outside IDLE
//   done         one-cycle pulse at the end of a job
//   stall_cnt    (OS_CTRL_PERF_EN only) saturating count of stalled cycles
// -----------------------------------------------------------------------------
module os_array_ctrl #(
  parameter int unsigned acc_kij  = 9,   // beats per channel pass, 1..16
  parameter int unsigned input_ch = 3,   // passes per output tile, 1..15
  parameter int unsigned row      = 8,   // words drained per tile
  parameter int unsigned skew     = 14   // pipeline flush cycles, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ififo_empty,
  input  logic        wfifo_empty,
  input  logic        ofifo_full,
  output logic [1:0]  inst_w,
  output logic        ififo_rd,
  output logic        wfifo_rd,
  output logic        ififo_loop,
  output logic        ofifo_wr,
  output logic        tile_sel,
  output logic [3:0]  kij_cnt,
  output logic        busy,
  output logic        done
`ifdef OS_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    SWAP  = 3'd2,
    FLUSH = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int unsigned FLUSH_W = (skew > 1) ? $clog2(skew) : 1;
  localparam int unsigned DRAIN_W = $clog2(2 * row);

  localparam logic [3:0]         KIJ_LAST   = 4'(acc_kij - 1);
  localparam logic [3:0]         IC_LAST    = 4'(input_ch);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(skew - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * row - 1);

  state_t              state_reg;
  logic [3:0]          kij_cnt_reg;
  logic                tile_sel_reg;
  logic [1:0][3:0]     ic_cnt_reg;
  logic [FLUSH_W-1:0]  flush_cnt_reg;
  logic [DRAIN_W-1:0]  drain_cnt_reg;

  logic                beat;
  logic                drain_wr;
  logic [1:0][3:0]     ic_next;
  logic [1:0]          ic_full;

  // A beat needs both operands present; the pops and the execute go out in
  // the same cycle so activations and weights stay aligned in the array.
  assign beat     = (state_reg == EXEC) && !ififo_empty && !wfifo_empty;
  // Never push while the OFIFO is full; the drain counter holds instead.
  assign drain_wr = (state_reg == DRAIN) && !ofifo_full;

  // Per-tile pass count after the SWAP increment of the tile just finished.
  for (genvar gi = 0; gi < 2; gi++) begin : g_tile
    assign ic_next[gi] = ic_cnt_reg[gi] + ((tile_sel_reg == 1'(gi)) ? 4'd1 : 4'd0);
    assign ic_full[gi] = (ic_next[gi] == IC_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      kij_cnt_reg   <= 4'd0;
      tile_sel_reg  <= 1'b0;
      ic_cnt_reg    <= '0;
      flush_cnt_reg <= '0;
      drain_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= EXEC;
        end
        EXEC: begin
          if (beat) begin
            if (kij_cnt_reg == KIJ_LAST) begin
              kij_cnt_reg <= 4'd0;
              state_reg   <= SWAP;
            end else begin
              kij_cnt_reg <= kij_cnt_reg + 4'd1;
            end
          end
        end
        SWAP: begin
          ic_cnt_reg   <= ic_next;
          tile_sel_reg <= ~tile_sel_reg;
          state_reg    <= (&ic_full) ? FLUSH : EXEC;
        end
        FLUSH: begin
          if (flush_cnt_reg == FLUSH_LAST) begin
            flush_cnt_reg <= '0;
            state_reg     <= DRAIN;
          end else begin
            flush_cnt_reg <= flush_cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_wr) begin
            if (drain_cnt_reg == DRAIN_LAST) begin
              drain_cnt_reg <= '0;
              state_reg     <= DONE;
            end else begin
              drain_cnt_reg <= drain_cnt_reg + 1'b1;
            end
          end
        end
        DONE: begin
          ic_cnt_reg   <= '0;
          tile_sel_reg <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Handshake outputs follow the FIFO flags in the same cycle; everything
  // else is decoded from registered state, so reset forces all of them low.
  assign inst_w     = {beat, 1'b0};
  assign ififo_rd   = beat;
  assign wfifo_rd   = beat;
  // Tile 1 is the second user of each activation window, so the rewind
  // happens after its pass.
  assign ififo_loop = (state_reg == SWAP) && tile_sel_reg;
  assign ofifo_wr   = drain_wr;
  assign tile_sel   = tile_sel_reg;
  assign kij_cnt    = kij_cnt_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);

`ifdef OS_CTRL_PERF_EN
  logic [15:0] stall_cnt_reg;
  logic        stall_event;

  assign stall_event = ((state_reg == EXEC) && !beat) ||
                       ((state_reg == DRAIN) && ofifo_full);

  // Cleared when a job starts, otherwise kept so software can read it after done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_reg <= 16'd0;
    end else if ((state_reg == IDLE) && start) begin
      stall_cnt_reg <= 16'd0;
    end else if (stall_event && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_os_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_os_array_ctrl
//   Directed bench for os_array_ctrl with default parameters. Inputs change on
//   the falling edge and outputs are sampled 1 time unit later. Expected
//   values are hand-derived: 54 beats, 3 rewinds, 16 writes and a start-to-done
//   span of 92 cycles (start cycle and done cycle inclusive) plus one cycle per
//   injected stall.
// -----------------------------------------------------------------------------
module tb_os_array_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ififo_empty;
  logic        wfifo_empty;
  logic        ofifo_full;
  logic [1:0]  inst_w;
  logic        ififo_rd;
  logic        wfifo_rd;
  logic        ififo_loop;
  logic        ofifo_wr;
  logic        tile_sel;
  logic [3:0]  kij_cnt;
  logic        busy;
  logic        done;
`ifdef OS_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  os_array_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ififo_empty (ififo_empty),
    .wfifo_empty (wfifo_empty),
    .ofifo_full  (ofifo_full),
    .inst_w      (inst_w),
    .ififo_rd    (ififo_rd),
    .wfifo_rd    (wfifo_rd),
    .ififo_loop  (ififo_loop),
    .ofifo_wr    (ofifo_wr),
    .tile_sel    (tile_sel),
    .kij_cnt     (kij_cnt),
    .busy        (busy),
    .done        (done)
`ifdef OS_CTRL_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_inst_w"}, 32'(inst_w), 0);
    check({tag, "_rd"}, 32'({ififo_rd, wfifo_rd}), 0);
    check({tag, "_pulses"}, 32'({ififo_loop, ofifo_wr, done}), 0);
    check({tag, "_tile_sel"}, 32'(tile_sel), 0);
    check({tag, "_kij_cnt"}, 32'(kij_cnt), 0);
  endtask

  // One full job. ie_len stall cycles of ififo_empty at kij_cnt=3 of the first
  // pass, of_len cycles of ofifo_full after the fifth drained word. A stray
  // start pulse is driven twice while busy and must change nothing.
  task automatic run_job(input string name, input int ie_len, input int of_len);
    int cyc;
    int beats;
    int loops;
    int writes;
    int ie_cnt;
    int of_cnt;
    bit stall_i;
    bit stall_o;
    bit got_done;
    cyc = 1; beats = 0; loops = 0; writes = 0; ie_cnt = 0; of_cnt = 0;
    got_done = 1'b0;
    @(negedge clk);
    start = 1'b1; ififo_empty = 1'b0; wfifo_empty = 1'b0; ofifo_full = 1'b0;
    #1;
    check({name, "_idle_before_start"}, 32'(busy), 0);
    while (!got_done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 20 || cyc == 80);
      stall_i = 1'b0;
      stall_o = 1'b0;
      if (beats == 3 && ie_cnt < ie_len) begin
        ififo_empty = 1'b1; ie_cnt++; stall_i = 1'b1;
      end else begin
        ififo_empty = 1'b0;
      end
      if (writes == 5 && of_cnt < of_len) begin
        ofifo_full = 1'b1; of_cnt++; stall_o = 1'b1;
      end else begin
        ofifo_full = 1'b0;
      end
      #1;
      if (cyc == 2) check({name, "_busy_after_start"}, 32'(busy), 1);
      if (inst_w == 2'b10) beats++;
      if (ififo_loop) loops++;
      if (ofifo_wr) writes++;
      check({name, "_rd_lockstep"}, 32'({ififo_rd, wfifo_rd}), 32'({2{inst_w == 2'b10}}));
      if (stall_i) begin
        check({name, "_bubble_inst_w"}, 32'(inst_w), 0);
        check({name, "_bubble_kij_hold"}, 32'(kij_cnt), 3);
      end
      if (stall_o) check({name, "_wr_while_full"}, 32'(ofifo_wr), 0);
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    ififo_empty = 1'b0;
    ofifo_full = 1'b0;
    check({name, "_done_seen"}, 32'(got_done), 1);
    check({name, "_latency"}, 32'(cyc), 32'(92 + ie_len + of_len));
    check({name, "_beats"}, 32'(beats), 54);
    check({name, "_loops"}, 32'(loops), 3);
    check({name, "_writes"}, 32'(writes), 16);
    check({name, "_bubbles"}, 32'(ie_cnt), 32'(ie_len));
`ifdef OS_CTRL_PERF_EN
    check({name, "_stall_cnt"}, 32'(stall_cnt), 32'(ie_len + of_len));
`endif
    @(negedge clk);
    #1;
    check({name, "_done_one_cycle"}, 32'(done), 0);
    check({name, "_idle_after_done"}, 32'(busy), 0);
    check({name, "_tile_sel_cleared"}, 32'(tile_sel), 0);
`ifdef OS_CTRL_PERF_EN
    check({name, "_stall_cnt_hold"}, 32'(stall_cnt), 32'(ie_len + of_len));
`endif
    $display("job %s: cycles=%0d beats=%0d loops=%0d writes=%0d", name, cyc, beats, loops, writes);
  endtask

  initial begin
    bit found;
    reset = 1'b0; start = 1'b0;
    ififo_empty = 1'b0; wfifo_empty = 1'b0; ofifo_full = 1'b0;
    #2;
    check_all_low("por");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("idle_no_start", 32'(busy), 0);

    run_job("nostall", 0, 0);
    run_job("ififo_stall", 4, 0);
    run_job("ofifo_stall", 0, 3);
    run_job("both_stall", 4, 3);
    run_job("rerun", 0, 0);

    // Asynchronous reset in the middle of the second pass.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      #1;
      if (tile_sel && kij_cnt == 4'd5) found = 1'b1;
    end
    check("rst_reached_point", 32'(found), 1);
    check("rst_pre_inst_w", 32'(inst_w), 2);
    #2;
    reset = 1'b0;
    #1;
    check_all_low("rst_mid_job");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stays_idle", 32'(busy), 0);
    $display("reset mid-job: checked");

    run_job("after_reset", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
